// File: rtl/key_decoder_pkg.sv
// Shared scancode-set-2 constants, decoder state encoding and held-key record.
// The KEY_WASD_EN macro adds the WASD alias bits to the held-key record.
package kbd_pkg;

    localparam logic [7:0] SC_SPACE  = 8'h29;
    localparam logic [7:0] SC_LEFT   = 8'h6B;
    localparam logic [7:0] SC_RIGHT  = 8'h74;
    localparam logic [7:0] SC_A      = 8'h1C;
    localparam logic [7:0] SC_D      = 8'h23;
    localparam logic [7:0] SC_W      = 8'h1D;
    localparam logic [7:0] SC_EXT    = 8'hE0;
    localparam logic [7:0] SC_PAUSE  = 8'hE1;
    localparam logic [7:0] SC_BREAK  = 8'hF0;
    localparam logic [7:0] SC_BAT    = 8'hAA;
    localparam logic [7:0] SC_ACK    = 8'hFA;
    localparam logic [7:0] SC_RESEND = 8'hFE;
    localparam logic [7:0] SC_ERR0   = 8'h00;
    localparam logic [7:0] SC_ERR1   = 8'hFF;

    // Bytes that follow E1 in the pause sequence and must be swallowed.
    localparam logic [2:0] SKIP_LEN  = 3'd7;

    typedef enum logic [2:0] {
        IDLE,
        EXT,
        BRK,
        EXT_BRK,
        SKIP
    } state_t;

    typedef struct packed {
        logic space;
        logic left;
        logic right;
`ifdef KEY_WASD_EN
        logic w;
        logic a;
        logic d;
`endif
    } held_t;

    function automatic logic is_prefix(input logic [7:0] b);
        return (b == SC_EXT) || (b == SC_PAUSE);
    endfunction

endpackage

// File: rtl/key_decoder_if.sv
// Byte stream from the PS/2 receiver plus the decoded key levels and error pulse.
interface key_decoder_if;

    logic [7:0] rx_data;
    logic       rx_valid;
    logic       key_space;
    logic       key_left;
    logic       key_right;
    logic       seq_err;

    modport master (
        output rx_data, rx_valid,
        input  key_space, key_left, key_right, seq_err
    );

    modport slave (
        input  rx_data, rx_valid,
        output key_space, key_left, key_right, seq_err
    );

endinterface

// File: rtl/key_decoder.sv
// Scancode-set-2 decoder for space/left/right with prefix tracking and stall timeout.
// Define KEY_WASD_EN to alias W/A/D onto space/left/right.
module key_decoder
    import kbd_pkg::*;
#(
    parameter int TIMEOUT_CYCLES = 100_000
) (
    input  logic          clk,
    input  logic          rst,
    key_decoder_if.slave  bus
);

    localparam int              CNT_W    = (TIMEOUT_CYCLES > 2) ? $clog2(TIMEOUT_CYCLES) : 1;
    localparam logic [CNT_W-1:0] TMO_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    state_t           state_q, state_d;
    logic [2:0]       skip_q, skip_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    held_t            held_q, held_d;
    logic             err_q, err_d;

    logic             special_clr;
    logic             special_err;
    logic             ignored;
    logic             tmo;

    assign special_clr = (bus.rx_data == SC_BAT);
    assign special_err = (bus.rx_data == SC_ERR0) || (bus.rx_data == SC_ERR1);
    assign ignored     = (bus.rx_data == SC_ACK) || (bus.rx_data == SC_RESEND);
    // A byte on the expiry cycle wins, so expiry only counts without rx_valid.
    assign tmo         = (state_q != IDLE) && (cnt_q == TMO_LAST) && !bus.rx_valid;

    function automatic held_t apply_code(input held_t h, input logic [7:0] code,
                                         input logic ext, input logic mk);
        held_t r;
        r = h;
        if (!ext && code == SC_SPACE) r.space = mk;
        if ( ext && code == SC_LEFT)  r.left  = mk;
        if ( ext && code == SC_RIGHT) r.right = mk;
`ifdef KEY_WASD_EN
        if (!ext && code == SC_W)     r.w     = mk;
        if (!ext && code == SC_A)     r.a     = mk;
        if (!ext && code == SC_D)     r.d     = mk;
`endif
        return r;
    endfunction

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            skip_q  <= '0;
            cnt_q   <= '0;
            held_q  <= '0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            skip_q  <= skip_d;
            cnt_q   <= cnt_d;
            held_q  <= held_d;
            err_q   <= err_d;
        end
    end

    always_comb begin : next_state
        state_d = state_q;
        skip_d  = skip_q;
        if (bus.rx_valid) begin
            if (special_clr || special_err) begin
                state_d = IDLE;
                skip_d  = '0;
            end else if (!ignored) begin
                unique case (state_q)
                    IDLE, EXT, BRK, EXT_BRK: begin
                        if (bus.rx_data == SC_EXT) begin
                            state_d = EXT;
                        end else if (bus.rx_data == SC_PAUSE) begin
                            state_d = SKIP;
                            skip_d  = SKIP_LEN;
                        end else if (bus.rx_data == SC_BREAK && state_q == IDLE) begin
                            state_d = BRK;
                        end else if (bus.rx_data == SC_BREAK && state_q == EXT) begin
                            state_d = EXT_BRK;
                        end else begin
                            state_d = IDLE;
                        end
                    end
                    SKIP: begin
                        if (skip_q <= 3'd1) begin
                            state_d = IDLE;
                            skip_d  = '0;
                        end else begin
                            skip_d  = skip_q - 3'd1;
                        end
                    end
                    default: state_d = IDLE;
                endcase
            end
        end else if (tmo) begin
            state_d = IDLE;
            skip_d  = '0;
        end
    end

    always_comb begin : outputs
        held_d = held_q;
        err_d  = 1'b0;
        cnt_d  = '0;
        if (!bus.rx_valid && state_q != IDLE && !tmo) cnt_d = cnt_q + CNT_W'(1);
        if (bus.rx_valid) begin
            if (special_clr) begin
                held_d = '0;
            end else if (special_err) begin
                held_d = '0;
                err_d  = 1'b1;
            end else if (!ignored) begin
                unique case (state_q)
                    IDLE: begin
                        if (!is_prefix(bus.rx_data) && bus.rx_data != SC_BREAK)
                            held_d = apply_code(held_q, bus.rx_data, 1'b0, 1'b1);
                    end
                    EXT: begin
                        if (is_prefix(bus.rx_data)) err_d = 1'b1;
                        else if (bus.rx_data != SC_BREAK)
                            held_d = apply_code(held_q, bus.rx_data, 1'b1, 1'b1);
                    end
                    BRK, EXT_BRK: begin
                        if (is_prefix(bus.rx_data)) err_d = 1'b1;
                        else held_d = apply_code(held_q, bus.rx_data, state_q == EXT_BRK, 1'b0);
                    end
                    default: ;
                endcase
            end
        end else if (tmo) begin
            err_d = 1'b1;
        end
    end

`ifdef KEY_WASD_EN
    assign bus.key_space = held_q.space | held_q.w;
    assign bus.key_left  = held_q.left  | held_q.a;
    assign bus.key_right = held_q.right | held_q.d;
`else
    assign bus.key_space = held_q.space;
    assign bus.key_left  = held_q.left;
    assign bus.key_right = held_q.right;
`endif
    assign bus.seq_err   = err_q;

endmodule

// File: tb/tb_key_decoder.sv
// Bench for key_decoder: fixed vector table, directed corner sequences, and random
// bytes checked against a sequence-level model of the scancode rules.
module tb_key_decoder;

    localparam int T = 16;

    logic clk;
    logic rst;
    key_decoder_if bus();

    key_decoder #(.TIMEOUT_CYCLES(T)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Model: the bytes of the sequence collected so far, pause bytes still to swallow,
    // stalled cycles, and the held level of each physical key.
    logic [7:0] pend[$];
    int  skip_left;
    int  idle_n;
    bit  m_sp, m_l, m_r, m_w, m_a, m_d, m_err;

    task automatic model_reset();
        pend.delete();
        skip_left = 0;
        idle_n = 0;
        {m_sp, m_l, m_r, m_w, m_a, m_d, m_err} = '0;
    endtask

    function automatic bit pend_has(input logic [7:0] b);
        foreach (pend[i]) if (pend[i] == b) return 1'b1;
        return 1'b0;
    endfunction

    task automatic model_apply(input logic [7:0] code);
        bit ext, mk;
        ext = pend_has(8'hE0);
        mk  = !pend_has(8'hF0);
        if (!ext && code == 8'h29) m_sp = mk;
        if ( ext && code == 8'h6B) m_l  = mk;
        if ( ext && code == 8'h74) m_r  = mk;
`ifdef KEY_WASD_EN
        if (!ext && code == 8'h1D) m_w = mk;
        if (!ext && code == 8'h1C) m_a = mk;
        if (!ext && code == 8'h23) m_d = mk;
`endif
    endtask

    task automatic model_cycle(input bit v, input logic [7:0] d);
        bit busy;
        busy  = (pend.size() > 0) || (skip_left > 0);
        m_err = 1'b0;
        if (v) begin
            idle_n = 0;
            if (d == 8'hAA || d == 8'h00 || d == 8'hFF) begin
                {m_sp, m_l, m_r, m_w, m_a, m_d} = '0;
                m_err = (d != 8'hAA);
                pend.delete();
                skip_left = 0;
            end else if (d == 8'hFA || d == 8'hFE) begin
            end else if (skip_left > 0) begin
                skip_left--;
            end else if (d == 8'hE0 || d == 8'hE1) begin
                if (pend.size() > 0) m_err = 1'b1;
                pend.delete();
                if (d == 8'hE1) skip_left = 7;
                else pend.push_back(d);
            end else if (d == 8'hF0 && !pend_has(8'hF0)) begin
                pend.push_back(d);
            end else begin
                model_apply(d);
                pend.delete();
            end
        end else if (busy) begin
            idle_n++;
            if (idle_n == T) begin
                m_err = 1'b1;
                pend.delete();
                skip_left = 0;
                idle_n = 0;
            end
        end
    endtask

    function automatic int exp_vec();
        return int'({m_err, m_r | m_d, m_l | m_a, m_sp | m_w});
    endfunction

    function automatic int outs();
        return int'({bus.seq_err, bus.key_right, bus.key_left, bus.key_space});
    endfunction

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %b expected %b (t=%0t)", name, act[3:0], exp[3:0], $time);
        end
    endtask

    task automatic step(input bit v, input logic [7:0] d);
        @(negedge clk);
        bus.rx_valid = v;
        bus.rx_data  = d;
        model_cycle(v, d);
        @(posedge clk);
        #1;
        chk("model", outs(), exp_vec());
    endtask

    task automatic do_reset();
        @(negedge clk);
        bus.rx_valid = 1'b0;
        rst = 1'b1;
        model_reset();
        #1;
        chk("reset", outs(), 0);
        @(negedge clk);
        chk("reset_hold", outs(), 0);
        rst = 1'b0;
    endtask

    typedef struct {
        bit         v;
        logic [7:0] d;
        logic [3:0] e;   // {seq_err, right, left, space} after the edge
    } vec_t;
    vec_t tbl[$];

    task automatic add(input bit v, input logic [7:0] d, input logic [3:0] e);
        vec_t x;
        x.v = v; x.d = d; x.e = e;
        tbl.push_back(x);
    endtask

    logic [7:0] pool [16] = '{8'h29, 8'h6B, 8'h74, 8'hE0, 8'hF0, 8'hE0, 8'hF0, 8'hE1,
                              8'hAA, 8'hFA, 8'hFE, 8'h00, 8'hFF, 8'h1C, 8'h23, 8'h1D};

    function automatic logic [7:0] rand_byte();
        if ($urandom_range(0, 7) == 0) return 8'($urandom);
        return pool[$urandom_range(0, 15)];
    endfunction

    logic [7:0] pause_seq [8] = '{8'hE1, 8'h14, 8'h77, 8'hE1, 8'hF0, 8'h14, 8'hF0, 8'h77};

    initial begin
        int nerr;
        rst = 1'b0;
        bus.rx_valid = 1'b0;
        bus.rx_data  = 8'h00;
        model_reset();
        do_reset();

        add(1, 8'h29, 4'b0001); add(0, 8'h00, 4'b0001);
        add(1, 8'hF0, 4'b0001); add(1, 8'h29, 4'b0000);
        add(1, 8'hE0, 4'b0000); add(1, 8'h6B, 4'b0010);
        add(1, 8'h6B, 4'b0010);
        add(1, 8'hE0, 4'b0010); add(1, 8'h74, 4'b0110);
        add(1, 8'hE0, 4'b0110); add(1, 8'hF0, 4'b0110); add(1, 8'h6B, 4'b0100);
        add(1, 8'hFA, 4'b0100); add(1, 8'hF0, 4'b0100); add(1, 8'hFE, 4'b0100);
        add(1, 8'h74, 4'b0100);
        add(1, 8'hE0, 4'b0100); add(1, 8'hE0, 4'b1100);
        add(1, 8'hF0, 4'b0100); add(1, 8'h74, 4'b0000);
        add(1, 8'h29, 4'b0001); add(1, 8'hE0, 4'b0001); add(1, 8'hE1, 4'b1001);
        add(1, 8'hF0, 4'b0001); add(1, 8'h29, 4'b0001); add(1, 8'hE0, 4'b0001);
        add(1, 8'h6B, 4'b0001); add(1, 8'h14, 4'b0001); add(1, 8'h77, 4'b0001);
        add(1, 8'h77, 4'b0001);
        add(1, 8'hFF, 4'b1000); add(0, 8'h00, 4'b0000);

        foreach (tbl[i]) begin
            step(tbl[i].v, tbl[i].d);
            chk($sformatf("table[%0d]", i), outs(), int'(tbl[i].e));
        end

        // Stall after E0: one error pulse, then 74 is a plain (unmapped) code.
        do_reset();
        step(1, 8'hE0);
        nerr = 0;
        for (int i = 0; i < T + 2; i++) begin
            step(0, 8'h00);
            if (bus.seq_err) nerr++;
        end
        chk("tmo_err_once", nerr, 1);
        step(1, 8'h74);
        chk("tmo_right_low", outs(), 0);
        step(1, 8'h29);
        chk("tmo_idle_space", outs(), 4'b0001);

        // Byte on the expiry cycle is still decoded as part of the sequence.
        do_reset();
        step(1, 8'hE0);
        for (int i = 0; i < T - 1; i++) step(0, 8'h00);
        step(1, 8'h74);
        chk("tmo_priority", outs(), 4'b0100);

        // Pause sequence with space held leaves everything alone.
        do_reset();
        step(1, 8'h29);
        for (int i = 0; i < 8; i++) begin
            step(1, pause_seq[i]);
            chk("pause_quiet", outs(), 4'b0001);
        end
        step(1, 8'hF0);
        step(1, 8'h29);
        chk("pause_idle", outs(), 0);

        // BAT clears held keys.
        do_reset();
        step(1, 8'h29); step(1, 8'hE0); step(1, 8'h6B);
        chk("bat_pre", outs(), 4'b0011);
        step(1, 8'hAA);
        chk("bat_clear", outs(), 0);

        // Reset mid-sequence drops the pending E0 F0.
        do_reset();
        step(1, 8'hE0); step(1, 8'hF0);
        do_reset();
        step(1, 8'h29);
        chk("rst_mid_space", outs(), 4'b0001);

`ifdef KEY_WASD_EN
        do_reset();
        step(1, 8'h1C);                 chk("wasd_a", outs(), 4'b0010);
        step(1, 8'hE0); step(1, 8'h6B); chk("wasd_both", outs(), 4'b0010);
        step(1, 8'hF0); step(1, 8'h1C); chk("wasd_a_rel", outs(), 4'b0010);
        step(1, 8'hE0); step(1, 8'hF0); step(1, 8'h6B);
        chk("wasd_left_rel", outs(), 0);
`endif

        do_reset();
        for (int i = 0; i < 2500; i++) begin
            int r;
            r = $urandom_range(0, 99);
            if (r < 4) begin
                for (int k = 0; k < T + 4; k++) step(0, 8'($urandom));
            end else if (r < 45) begin
                step(1, rand_byte());
            end else begin
                step(0, 8'($urandom));
            end
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/key_decoder.md
KEY_DECODER -- requirements
Module: key_decoder

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 100_000: clk cycles a multi-byte sequence may stall before the decoder abandons it.
REQ-002 SHALL have port clk, input, 1: single system clock; all logic is rising-edge.
REQ-003 SHALL have port rst, input, 1: reset, asynchronous and active-high.
REQ-004 SHALL have port rx_data, input, 8: scancode-set-2 byte from the PS/2 receiver.
REQ-005 SHALL have port rx_valid, input, 1: one-cycle strobe qualifying rx_data.
REQ-006 SHALL have port key_space, output, 1: registered level, high while space is held.
REQ-007 SHALL have port key_left, output, 1: registered level, high while left arrow is held.
REQ-008 SHALL have port key_right, output, 1: registered level, high while right arrow is held.
REQ-009 SHALL have port seq_err, output, 1: one-cycle pulse on timeout, 0x00/0xFF error byte, or an unexpected prefix.

Function
REQ-010 SHALL implement FSM states IDLE, EXT (E0 seen), BRK (F0 seen), EXT_BRK (E0 F0 seen), SKIP (E1 pause sequence).
REQ-011 SHALL handle bytes received in IDLE as follows: E0 -> EXT; F0 -> BRK; E1 -> SKIP with skip count 7; any other byte is a make code, decoded and stays in IDLE.
REQ-012 SHALL handle bytes received in EXT as follows: F0 -> EXT_BRK; any other byte is an extended make code -> IDLE.
REQ-013 SHALL treat any byte in BRK as a break code -> IDLE, and any byte in EXT_BRK as an extended break code -> IDLE.
REQ-014 SHALL set the key output high on a make code and low on a break code, using this mapping: 0x29 (non-extended) = space; E0 6B = left; E0 74 = right.
REQ-015 SHALL leave the outputs unchanged for unmapped codes, including 6B or 74 without the E0 prefix (keypad 4/6).
REQ-016 SHALL, in SKIP, decrement the skip count on each rx_valid and return to IDLE after the 7th byte; no outputs change during SKIP.
REQ-017 SHALL, on 0xAA (BAT complete) in any state, clear all keys and go to IDLE.
REQ-018 SHALL, on 0x00 or 0xFF in any state, clear all keys, pulse seq_err, and go to IDLE.
REQ-019 SHALL ignore 0xFA (ack) and 0xFE (resend) in every state, with no state change.
REQ-020 SHALL treat E0 or E1 arriving in EXT, BRK or EXT_BRK as a fresh prefix: seq_err pulses and the FSM re-enters EXT or SKIP respectively.
REQ-021 SHALL register the outputs so that they update on the clk edge after the cycle in which rx_valid carries the final byte (latency 1).
REQ-022 SHALL keep a timeout counter that clears on every rx_valid and counts only while not in IDLE.
REQ-023 SHALL, when the timeout counter reaches TIMEOUT_CYCLES-1, return the FSM to IDLE, pulse seq_err, and leave the key levels unchanged.
REQ-024 SHALL give rx_valid priority when it coincides with timeout expiry: the byte is processed in the current state and no seq_err is raised.
REQ-025 SHALL NOT arbitrate between simultaneously held keys: left and right may both be high, and the consumer resolves priority.
REQ-026 SHALL re-assert an output that is already high on a repeated make code (typematic), which produces no visible change.

Reset
REQ-027 SHALL, while rst is high, asynchronously force FSM=IDLE, all key outputs 0, seq_err 0, the timeout counter 0 and the skip count 0.
REQ-028 SHALL, when rst is asserted mid-sequence, discard the partial sequence; the first byte after release is decoded from IDLE.

Configuration
REQ-029 SHALL, with KEY_WASD_EN defined, additionally map non-extended 0x1C (A) = left, 0x23 (D) = right, 0x1D (W) = space.
REQ-030 SHALL, when an output has two mapped sources, drive it as the OR of two internal held bits, so releasing one source does not clear the other.
REQ-031 SHALL, without KEY_WASD_EN, treat 0x1C, 0x23 and 0x1D as unmapped and omit the alias bits entirely.

Structure
REQ-032 SHALL place the scancode constants (0x29, 0x6B, 0x74, 0x1C, 0x23, 0x1D, E0, E1, F0, AA, FA, FE) and the FSM state enum typedef in shared package kbd_pkg.
REQ-033 SHALL be implemented as a single module with the timeout counter inline; no sub-module is needed, and the PS/2 bit-level receiver is a separate upstream block.

Verification
REQ-034 SHALL cover: bytes 29, then F0 29 -> key_space rises 1 cycle after the 29 strobe and falls 1 cycle after the second 29 strobe.
REQ-035 SHALL cover: E0 6B, E0 74, E0 F0 6B -> left=1, right=1, then left=0 with right still 1; plain 6B leaves left unchanged.
REQ-036 SHALL cover: E0 followed by a TIMEOUT_CYCLES gap, then 74 -> seq_err pulses once, FSM is back in IDLE, and key_right stays 0.
REQ-037 SHALL cover: the 8-byte pause sequence E1 14 77 E1 F0 14 F0 77 -> no output change, no seq_err, FSM ends in IDLE.
REQ-038 SHALL cover: space and left held, then AA -> all keys 0; in a second run, rst asserted after E0 F0 leaves outputs at 0 and a subsequent 29 sets space.
REQ-039 SHALL cover, with KEY_WASD_EN defined: 1C, E0 6B, F0 1C -> key_left stays 1 until E0 F0 6B is received.
